// File: rtl/uart_rom_loader.sv
// uart_rom_loader: boot-time program loader.
// Receives 8N1 serial bytes, takes a 16-bit little-endian word count, packs the
// following bytes into little-endian 32-bit words and writes them to the
// instruction ROM. The CPU is held in reset until the last word is written.
module uart_rom_loader #(
    parameter int WAIT   = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam int CW = (WAIT > 2) ? $clog2(WAIT) : 1;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] LD_LEN_LO = 2'd0;
    localparam logic [1:0] LD_LEN_HI = 2'd1;
    localparam logic [1:0] LD_DATA   = 2'd2;
    localparam logic [1:0] LD_DONE   = 2'd3;

    logic [1:0]        r_sync;
    logic [1:0]        r_rx_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_byte_valid;
    logic              r_frame_err;

    logic [1:0]        r_ld_state;
    logic [15:0]       r_len;
    logic [15:0]       r_widx;
    logic [1:0]        r_bidx;
    logic [31:0]       r_word;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_cpu_reset;
    logic              r_busy;
    logic              r_done;

    logic              w_rxs;
    logic              w_in_range;
    logic [15:0]       w_len_full;

    assign w_rxs      = r_sync[1];
    assign w_in_range = ((r_widx >> ADDR_W) == 16'd0);
    assign w_len_full = {r_shift, r_len[7:0]};

    // Two-flop synchroniser for the asynchronous serial input (idle high).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], uart_rx};
    end

    // Serial receiver: the counter is cleared when the start edge is seen, so
    // the START sample lands WAIT/2 clocks later (mid-bit) and every later
    // sample is a whole bit period after the previous one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state   <= RX_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!w_rxs) begin
                        r_cnt      <= '0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt == CW'(WAIT/2 - 1)) begin
                        r_cnt      <= '0;
                        r_bit      <= '0;
                        r_rx_state <= w_rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CW'(WAIT - 1)) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxs, r_shift[7:1]};
                        if (r_bit == 3'd7) r_rx_state <= RX_STOP;
                        else               r_bit      <= r_bit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_cnt == CW'(WAIT - 1)) begin
                        r_cnt      <= '0;
                        r_rx_state <= RX_IDLE;
                        if (w_rxs) r_byte_valid <= 1'b1;
                        else       r_frame_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Loader: header, word packing and ROM write strobe, stepped by received bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld_state  <= LD_LEN_LO;
            r_len       <= '0;
            r_widx      <= '0;
            r_bidx      <= '0;
            r_word      <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_byte_valid) begin
                if (r_ld_state != LD_DONE) r_busy <= 1'b1;
                case (r_ld_state)
                    LD_LEN_LO: begin
                        r_len[7:0] <= r_shift;
                        r_ld_state <= LD_LEN_HI;
                    end
                    LD_LEN_HI: begin
                        r_len[15:8] <= r_shift;
                        if (w_len_full == 16'd0) begin
                            r_ld_state  <= LD_DONE;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_ld_state <= LD_DATA;
                            r_widx     <= '0;
                            r_bidx     <= '0;
                        end
                    end
                    LD_DATA: begin
                        r_word <= {r_shift, r_word[31:8]};
                        r_bidx <= r_bidx + 1'b1;
                        if (r_bidx == 2'd3) begin
                            r_we    <= w_in_range;
                            r_waddr <= r_widx[ADDR_W-1:0];
                            r_wdata <= {r_shift, r_word[31:8]};
                            r_widx  <= r_widx + 1'b1;
                            if (r_widx == r_len - 16'd1) begin
                                r_ld_state  <= LD_DONE;
                                r_done      <= 1'b1;
                                r_busy      <= 1'b0;
                                r_cpu_reset <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rom_we    = r_we;
    assign rom_waddr = r_waddr;
    assign rom_wdata = r_wdata;
    assign cpu_reset = r_cpu_reset;
    assign busy      = r_busy;
    assign done      = r_done;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Bench for uart_rom_loader: two instances (ADDR_W=8 and ADDR_W=2) share one
// serial line and reset; a byte-level model predicts writes and status.
module tb_uart_rom_loader;

    localparam int WAIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rx;

    logic        we0, cpur0, busy0, done0, ferr0;
    logic [7:0]  waddr0;
    logic [31:0] wdata0;
    logic        we1, cpur1, busy1, done1, ferr1;
    logic [1:0]  waddr1;
    logic [31:0] wdata1;

    always #5 clk = ~clk;

    uart_rom_loader #(.WAIT(WAIT), .ADDR_W(8)) dut0 (
        .clk(clk), .reset(reset), .uart_rx(uart_rx),
        .rom_we(we0), .rom_waddr(waddr0), .rom_wdata(wdata0),
        .cpu_reset(cpur0), .busy(busy0), .done(done0), .frame_err(ferr0)
    );

    uart_rom_loader #(.WAIT(WAIT), .ADDR_W(2)) dut1 (
        .clk(clk), .reset(reset), .uart_rx(uart_rx),
        .rom_we(we1), .rom_waddr(waddr1), .rom_wdata(wdata1),
        .cpu_reset(cpur1), .busy(busy1), .done(done1), .frame_err(ferr1)
    );

    int checks = 0;
    int errors = 0;

    // Model: the accepted byte stream since reset, plus expected writes.
    logic [7:0]  m_bytes[$];
    bit          m_ferr;
    logic [39:0] exp0[$];
    logic [39:0] exp1[$];
    bit          stable;

    int          wr_cnt0, wr_cnt1;
    logic [7:0]  last_addr0;
    logic [31:0] last_data0;
    logic [1:0]  last_addr1;
    logic [31:0] last_data1;
    logic        prev_we0, prev_we1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_n();
        return (m_bytes.size() >= 2) ? int'({m_bytes[1], m_bytes[0]}) : -1;
    endfunction

    function automatic bit m_done();
        if (m_bytes.size() < 2) return 1'b0;
        return ((m_bytes.size() - 2) / 4) >= m_n();
    endfunction

    function automatic bit m_busy();
        return (m_bytes.size() >= 1) && !m_done();
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int sz, k;
        logic [31:0] word;
        if (m_done()) return;
        m_bytes.push_back(b);
        sz = m_bytes.size();
        if (sz >= 6 && ((sz - 2) % 4) == 0) begin
            k    = (sz - 2) / 4 - 1;
            word = {m_bytes[sz-1], m_bytes[sz-2], m_bytes[sz-3], m_bytes[sz-4]};
            if (k < 256) exp0.push_back({8'(k), word});
            if (k < 4)   exp1.push_back({6'd0, 2'(k), word});
        end
    endtask

    // Compare process: every write against the model queue, status whenever settled.
    always @(negedge clk) begin
        logic [39:0] e;
        chk("we0_pulse", we0 & prev_we0, 0);
        chk("we1_pulse", we1 & prev_we1, 0);
        if (we0) begin
            wr_cnt0++; last_addr0 = waddr0; last_data0 = wdata0;
            if (exp0.size() == 0) chk("we0_unexpected", 1, 0);
            else begin
                e = exp0.pop_front();
                chk("w0_addr", waddr0, e[39:32]);
                chk("w0_data", wdata0, e[31:0]);
            end
        end
        if (we1) begin
            wr_cnt1++; last_addr1 = waddr1; last_data1 = wdata1;
            if (exp1.size() == 0) chk("we1_unexpected", 1, 0);
            else begin
                e = exp1.pop_front();
                chk("w1_addr", waddr1, e[33:32]);
                chk("w1_data", wdata1, e[31:0]);
            end
        end
        if (stable) begin
            chk("done0", done0, m_done());
            chk("busy0", busy0, m_busy());
            chk("cpur0", cpur0, !m_done());
            chk("ferr0", ferr0, m_ferr);
            chk("done1", done1, m_done());
            chk("busy1", busy1, m_busy());
            chk("cpur1", cpur1, !m_done());
            chk("ferr1", ferr1, m_ferr);
        end
        prev_we0 = we0;
        prev_we1 = we1;
    end

    task automatic do_reset();
        stable = 1'b0;
        chk("pending_w0", exp0.size(), 0);
        chk("pending_w1", exp1.size(), 0);
        exp0.delete();
        exp1.delete();
        @(negedge clk);
        reset = 1'b1;
        m_bytes.delete();
        m_ferr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we0", we0, 0);
        chk("rst_cpur0", cpur0, 1);
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_ferr0", ferr0, 0);
        chk("rst_cpur1", cpur1, 1);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        wr_cnt0 = 0;
        wr_cnt1 = 0;
        stable  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        stable  = 1'b0;
        uart_rx = 1'b0;
        repeat (WAIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (WAIT) @(negedge clk);
        end
        if (stop_ok) model_byte(b);
        else         m_ferr = 1'b1;
        uart_rx = stop_ok;
        repeat (WAIT) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * WAIT) @(negedge clk);
        stable = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic glitch();
        stable  = 1'b0;
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * WAIT) @(negedge clk);
        stable = 1'b1;
    endtask

    task automatic send_t1();
        send(8'h01); send(8'h00);
        send(8'h03); send(8'h20); send(8'h00); send(8'h00);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, cut, nb;
        reset    = 1'b0;
        uart_rx  = 1'b1;
        stable   = 1'b0;
        m_ferr   = 1'b0;
        prev_we0 = 1'b0;
        prev_we1 = 1'b0;
        wr_cnt0  = 0;
        wr_cnt1  = 0;
        repeat (2) @(negedge clk);

        // 1: single word
        do_reset();
        send_t1();
        chk("t1_count", wr_cnt0, 1);
        chk("t1_addr", last_addr0, 8'h00);
        chk("t1_data", last_data0, 32'h00002003);
        chk("t1_done", done0, 1);
        chk("t1_cpur", cpur0, 0);
        chk("t1_ferr", ferr0, 0);

        // 2: two words
        do_reset();
        send(8'h02); send(8'h00);
        send(8'h03); send(8'h20); send(8'h00); send(8'h00);
        chk("t2_done_mid", done0, 0);
        send(8'h04); send(8'h30); send(8'h20); send(8'h00);
        chk("t2_count", wr_cnt0, 2);
        chk("t2_addr", last_addr0, 8'h01);
        chk("t2_data", last_data0, 32'h00203004);
        chk("t2_done", done0, 1);

        // 3: empty program
        do_reset();
        send(8'h00); send(8'h00);
        chk("t3_count", wr_cnt0, 0);
        chk("t3_done", done0, 1);
        chk("t3_cpur", cpur0, 0);

        // 4: glitch on the line is not a byte
        do_reset();
        glitch();
        chk("t4_busy", busy0, 0);
        send(8'h01); send(8'h00);
        send(8'h0A); send(8'h00); send(8'h00); send(8'h00);
        chk("t4_count", wr_cnt0, 1);
        chk("t4_data", last_data0, 32'h0000000A);
        chk("t4_addr", last_addr0, 8'h00);

        // 5: framing error then a normal load
        do_reset();
        send_frame(8'h55, 1'b0);
        chk("t5_ferr", ferr0, 1);
        chk("t5_busy", busy0, 0);
        send_t1();
        chk("t5_count", wr_cnt0, 1);
        chk("t5_data", last_data0, 32'h00002003);
        chk("t5_done", done0, 1);
        chk("t5_ferr_sticky", ferr0, 1);

        // 6: more words than ROM depth on the ADDR_W=2 instance
        do_reset();
        send(8'h05); send(8'h00);
        for (int w = 1; w <= 5; w++) begin
            send(8'(w)); send(8'h00); send(8'h00); send(8'h00);
        end
        chk("t6_count1", wr_cnt1, 4);
        chk("t6_addr1", last_addr1, 2'd3);
        chk("t6_data1", last_data1, 32'h00000004);
        chk("t6_done1", done1, 1);
        chk("t6_count0", wr_cnt0, 5);
        chk("t6_data0", last_data0, 32'h00000005);

        // 7: reset mid-word, then replay test 1
        do_reset();
        send(8'h01); send(8'h00); send(8'h03); send(8'h20);
        do_reset();
        chk("t7_count", wr_cnt0, 0);
        chk("t7_cpur", cpur0, 1);
        send_t1();
        chk("t7_count2", wr_cnt0, 1);
        chk("t7_data", last_data0, 32'h00002003);
        chk("t7_done", done0, 1);

        // Randomised loads with glitches, bad frames, trailing bytes and early resets
        for (int it = 0; it < 10; it++) begin
            do_reset();
            n   = $urandom_range(0, 6);
            nb  = 2 + 4 * n + $urandom_range(0, 2);
            cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb) : nb;
            for (int i = 0; i < cut; i++) begin
                case ($urandom_range(0, 7))
                    0: glitch();
                    1: send_frame(8'($urandom), 1'b0);
                    default: ;
                endcase
                if (i == 0)      send(8'(n));
                else if (i == 1) send(8'h00);
                else             send(8'($urandom));
            end
        end
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
